// File: rtl/cordic_vector.sv
// cordic_vector: iterative vectoring-mode CORDIC.
// Converts a signed Cartesian pair into an uncompensated magnitude (x K,
// K ~ 1.64676) and a binary angle (65536 LSB = pi rad), performing one
// micro-rotation per clock under a start/valid handshake.
//
// Ports:
//   clk      in   1   system clock, rising edge
//   rst      in   1   asynchronous active-high reset
//   start    in   1   request pulse, sampled only when idle
//   x_i      in  17   signed X input
//   y_i      in  17   signed Y input
//   busy     out  1   operation in progress
//   valid_o  out  1   one-cycle pulse, mag_o/theta_o updated
//   mag_o    out 19   unsigned magnitude x K
//   theta_o  out 17   signed angle, range [-65536, 65535]
module cordic_vector #(
  parameter int unsigned ITER = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [16:0] x_i,
  input  logic [16:0] y_i,
  output logic        busy,
  output logic        valid_o,
  output logic [18:0] mag_o,
  output logic [16:0] theta_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PRE  = 2'd1;
  localparam logic [1:0] S_ITER = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [3:0] LAST = 4'(ITER - 1);

  logic [1:0]         state_q, state_d;
  logic signed [19:0] x_q, x_d;
  logic signed [19:0] y_q, y_d;
  logic [16:0]        z_q, z_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               valid_q, valid_d;
  logic [18:0]        mag_q, mag_d;
  logic [16:0]        theta_q, theta_d;

  logic [16:0]        atan_c;
  logic signed [19:0] xs, ys;

  always_comb begin
    case (cnt_q)
      4'd0:    atan_c = 17'd16384;
      4'd1:    atan_c = 17'd9672;
      4'd2:    atan_c = 17'd5110;
      4'd3:    atan_c = 17'd2594;
      4'd4:    atan_c = 17'd1302;
      4'd5:    atan_c = 17'd652;
      4'd6:    atan_c = 17'd326;
      4'd7:    atan_c = 17'd163;
      4'd8:    atan_c = 17'd81;
      4'd9:    atan_c = 17'd41;
      4'd10:   atan_c = 17'd20;
      4'd11:   atan_c = 17'd10;
      4'd12:   atan_c = 17'd5;
      4'd13:   atan_c = 17'd3;
      default: atan_c = 17'd1;
    endcase
  end

  assign xs = x_q >>> cnt_q;
  assign ys = y_q >>> cnt_q;

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    cnt_d   = cnt_q;
    valid_d = 1'b0;
    mag_d   = mag_q;
    theta_d = theta_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          x_d     = {{3{x_i[16]}}, x_i};
          y_d     = {{3{y_i[16]}}, y_i};
          state_d = S_PRE;
        end
      end
      S_PRE: begin
        // Fold left half-plane into the right so the iterations only
        // have to cover +/-90 degrees; z starts at the fold angle.
        cnt_d = '0;
        if (!x_q[19]) begin
          z_d = '0;
        end else if (!y_q[19]) begin
          x_d = y_q;
          y_d = -x_q;
          z_d = 17'h08000;
        end else begin
          x_d = -y_q;
          y_d = x_q;
          z_d = 17'h18000;
        end
        state_d = S_ITER;
      end
      S_ITER: begin
        if (!y_q[19]) begin
          x_d = x_q + ys;
          y_d = y_q - xs;
          z_d = z_q + atan_c;
        end else begin
          x_d = x_q - ys;
          y_d = y_q + xs;
          z_d = z_q - atan_c;
        end
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == LAST) state_d = S_DONE;
      end
      S_DONE: begin
        mag_d   = x_q[18:0];
        theta_d = z_q;
        valid_d = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      mag_q   <= '0;
      theta_q <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      mag_q   <= mag_d;
      theta_q <= theta_d;
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign valid_o = valid_q;
  assign mag_o   = mag_q;
  assign theta_o = theta_q;

endmodule
